axi_traffic_gen: RTL

Parametrised AXI4 traffic generator for the DDR2 controller simulation bench, driving the controller's AXI slave port.
- Issues spaced write bursts with a deterministic address-derived data pattern.
- In MODE=1, reads each burst back and compares beat-by-beat, counting errors.
- Adds back-pressure-correct handshakes, burst count limit, read channel and status outputs.

---
 rtl/axi_traffic_gen.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axi_traffic_gen.sv
// AXI4 write/read-back traffic generator for the DDR2 controller bench.
// One burst in flight at a time; data is the address-derived beat pattern.
module axi_traffic_gen #(
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 8,
  parameter int ADDR_BASE   = 16,
  parameter int ADDR_STRIDE = 16,
  parameter int GAP_CYCLES  = 50,
  parameter int NUM_BURSTS  = 0,
  parameter int MODE        = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init_end,
  input  logic                  start,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  input  logic                  bvalid,
  input  logic [1:0]            bresp,
  output logic                  bready,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  input  logic                  rvalid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  output logic                  rready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           burst_cnt,
  output logic [15:0]           err_cnt
);

  localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam logic [15:0] LAST = 16'(BURST_LEN - 1);
  localparam logic [15:0] NB = 16'(NUM_BURSTS);
  localparam logic [31:0] GAP_TC =
    (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [3:0] {
    S_IDLE, S_GAP, S_AW, S_W, S_B, S_AR, S_R, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]           gap_cnt;
  logic [15:0]           beat;
  logic [DATA_WIDTH-1:0] pat_cur;
  logic [DATA_WIDTH-1:0] pat_nxt;
  logic                  go;
  logic                  gap_done;
  logic                  last_burst;
  logic [1:0]            r_err;
  logic [1:0]            err_inc;
  logic [16:0]           err_sum;
  logic [15:0]           err_nxt;

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [15:0]           i
  );
    logic [SW:0] s;
    s = (SW+1)'(a) + (SW+1)'(i);
    return s[DATA_WIDTH-1:0];
  endfunction

  assign awlen   = 8'(BURST_LEN - 1);
  assign arlen   = 8'(BURST_LEN - 1);
  assign araddr  = awaddr;
  assign pat_cur = pattern(awaddr, beat);
  assign pat_nxt = pattern(awaddr, beat + 16'd1);

  assign go         = start && init_end;
  assign gap_done   = init_end && (gap_cnt == GAP_TC);
  assign last_burst = (NUM_BURSTS != 0) && (burst_cnt + 16'd1 == NB);

  // A read beat can be wrong in data and in framing at the same time.
  assign r_err = {1'b0, rdata != pat_cur}
               + {1'b0, rlast != (beat == LAST)};

  always_comb begin
    err_inc = 2'd0;
    if (state == S_B && bvalid && bresp != 2'b00) err_inc = 2'd1;
    if (state == S_R && rvalid) err_inc = r_err;
  end

  assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};
  assign err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = S_GAP;
      end
      S_GAP: if (gap_done) state_nxt = S_AW;
      S_AW: begin
        awvalid = 1'b1;
        if (awready) state_nxt = S_W;
      end
      S_W: begin
        wvalid = 1'b1;
        wlast  = (beat == LAST);
        if (wready && wlast) state_nxt = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = (MODE != 0) ? S_AR : S_NEXT;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = S_NEXT;
      end
      S_NEXT: state_nxt = last_burst ? S_DONE : S_GAP;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (go) state_nxt = S_GAP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_cnt   <= '0;
      beat      <= '0;
      awaddr    <= BASE;
      wdata     <= '0;
      burst_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      err_cnt <= err_nxt;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            gap_cnt   <= '0;
            awaddr    <= BASE;
            burst_cnt <= '0;
            err_cnt   <= '0;
          end
        end
        S_GAP: if (init_end) gap_cnt <= gap_cnt + 32'd1;
        S_AW: begin
          if (awready) begin
            beat  <= '0;
            wdata <= pattern(awaddr, 16'd0);
          end
        end
        S_W: begin
          if (wready) begin
            beat  <= beat + 16'd1;
            wdata <= pat_nxt;
          end
        end
        S_AR: if (arready) beat <= '0;
        // Beat index saturates so a runaway read never aliases back to 0.
        S_R: begin
          if (rvalid && beat != 16'hFFFF) beat <= beat + 16'd1;
        end
        S_NEXT: begin
          gap_cnt   <= '0;
          burst_cnt <= burst_cnt + 16'd1;
          awaddr    <= awaddr + STRIDE;
        end
        default: ;
      endcase
    end
  end

endmodule
